// File: rtl/bsg_mem_2rw_byte_arb_ctrl.sv
// Round-robin arbiter sharing one 2rw byte-masked SRAM among reqs_p requesters.
// Grants up to two requests per cycle and zero-fills the memory after reset.

module bsg_mem_2rw_byte_arb_ctrl_resp_lane #(
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               i_rd_a,
  input  logic               i_rd_b,
  input  logic [width_p-1:0] i_a_data,
  input  logic [width_p-1:0] i_b_data,
  output logic               o_resp_v,
  output logic [width_p-1:0] o_resp_data
);
  logic r_v, r_from_b;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_v      <= 1'b0;
      r_from_b <= 1'b0;
    end else begin
      r_v      <= i_rd_a | i_rd_b;
      r_from_b <= i_rd_b;
    end
  end

  assign o_resp_v    = r_v;
  assign o_resp_data = r_from_b ? i_b_data : i_a_data;
endmodule

module bsg_mem_2rw_byte_arb_ctrl #(
  parameter int width_p         = 64,
  parameter int els_p           = 512,
  parameter int reqs_p          = 4,
  parameter int init_on_reset_p = 1,
  localparam int addr_width_lp  = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int mask_width_lp  = width_p / 8
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [reqs_p-1:0]                 req_v_i,
  input  logic [reqs_p-1:0]                 req_w_i,
  input  logic [reqs_p*addr_width_lp-1:0]   req_addr_i,
  input  logic [reqs_p*width_p-1:0]         req_data_i,
  input  logic [reqs_p*mask_width_lp-1:0]   req_mask_i,
  output logic [reqs_p-1:0]                 req_yumi_o,
  output logic [reqs_p-1:0]                 resp_v_o,
  output logic [reqs_p*width_p-1:0]         resp_data_o,
  output logic                              a_v_o,
  output logic                              a_w_o,
  output logic [addr_width_lp-1:0]          a_addr_o,
  output logic [width_p-1:0]                a_data_o,
  output logic [mask_width_lp-1:0]          a_w_mask_o,
  input  logic [width_p-1:0]                a_data_i,
  output logic                              b_v_o,
  output logic                              b_w_o,
  output logic [addr_width_lp-1:0]          b_addr_o,
  output logic [width_p-1:0]                b_data_o,
  output logic [mask_width_lp-1:0]          b_w_mask_o,
  input  logic [width_p-1:0]                b_data_i,
  output logic                              init_done_o
);
  localparam int ptr_w_lp     = $clog2(reqs_p);
  localparam int init_last_lp = (els_p + 1) / 2 - 1;

  typedef enum logic {S_INIT, S_RUN} state_e;
  localparam state_e RST_STATE = (init_on_reset_p != 0) ? S_INIT : S_RUN;

  state_e                   r_state, w_state_n;
  logic [addr_width_lp-1:0] r_cnt, w_cnt_n;
  logic [ptr_w_lp-1:0]      r_ptr, w_ptr_n;

  logic [reqs_p-1:0][addr_width_lp-1:0] w_addr;
  logic [reqs_p-1:0][width_p-1:0]       w_data;
  logic [reqs_p-1:0][mask_width_lp-1:0] w_mask;
  logic [reqs_p-1:0][width_p-1:0]       w_resp_data;

  assign w_addr      = req_addr_i;
  assign w_data      = req_data_i;
  assign w_mask      = req_mask_i;
  assign resp_data_o = w_resp_data;

  function automatic logic [ptr_w_lp-1:0] rot(input logic [ptr_w_lp-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= reqs_p) s = s - reqs_p;
    return ptr_w_lp'(s);
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= RST_STATE;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_ptr   <= w_ptr_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (r_state == S_INIT) begin
      w_cnt_n = r_cnt + 1'b1;
      if (r_cnt == addr_width_lp'(init_last_lp)) w_state_n = S_RUN;
    end
  end

  assign init_done_o = (r_state == S_RUN);

  // Two-deep priority scan starting at the round-robin pointer.
  logic                w_fa, w_fb, w_ga, w_gb, w_conflict;
  logic [ptr_w_lp-1:0] w_ia, w_ib;

  always_comb begin
    w_fa = 1'b0;
    w_fb = 1'b0;
    w_ia = '0;
    w_ib = '0;
    for (int off = 0; off < reqs_p; off++) begin
      if (req_v_i[rot(r_ptr, off)]) begin
        if (!w_fa) begin
          w_fa = 1'b1;
          w_ia = rot(r_ptr, off);
        end else if (!w_fb) begin
          w_fb = 1'b1;
          w_ib = rot(r_ptr, off);
        end
      end
    end
  end

  // Same-address pair is only safe when both are reads.
  assign w_conflict = w_fa & w_fb & (w_addr[w_ia] == w_addr[w_ib])
                    & (req_w_i[w_ia] | req_w_i[w_ib]);
  assign w_ga = init_done_o & w_fa;
  assign w_gb = init_done_o & w_fb & ~w_conflict;

  logic [reqs_p-1:0] w_rd_a, w_rd_b;

  always_comb begin
    req_yumi_o = '0;
    w_rd_a     = '0;
    w_rd_b     = '0;
    w_ptr_n    = r_ptr;
    if (w_ga) begin
      req_yumi_o[w_ia] = 1'b1;
      w_rd_a[w_ia]     = ~req_w_i[w_ia];
      w_ptr_n          = rot(w_ia, 1);
    end
    if (w_gb) begin
      req_yumi_o[w_ib] = 1'b1;
      w_rd_b[w_ib]     = ~req_w_i[w_ib];
      w_ptr_n          = rot(w_ib, 1);
    end
  end

  always_comb begin
    a_v_o      = 1'b0;
    a_w_o      = 1'b0;
    a_addr_o   = '0;
    a_data_o   = '0;
    a_w_mask_o = '0;
    b_v_o      = 1'b0;
    b_w_o      = 1'b0;
    b_addr_o   = '0;
    b_data_o   = '0;
    b_w_mask_o = '0;
    if (r_state == S_INIT) begin
      a_v_o      = 1'b1;
      a_w_o      = 1'b1;
      a_addr_o   = addr_width_lp'({r_cnt, 1'b0});
      a_w_mask_o = '1;
      // Odd depth: the last sweep step has no odd-address partner.
      if ({1'b0, r_cnt, 1'b1} < (addr_width_lp + 2)'(els_p)) begin
        b_v_o      = 1'b1;
        b_w_o      = 1'b1;
        b_addr_o   = addr_width_lp'({r_cnt, 1'b1});
        b_w_mask_o = '1;
      end
    end else begin
      if (w_ga) begin
        a_v_o      = 1'b1;
        a_w_o      = req_w_i[w_ia];
        a_addr_o   = w_addr[w_ia];
        a_data_o   = w_data[w_ia];
        a_w_mask_o = req_w_i[w_ia] ? w_mask[w_ia] : '0;
      end
      if (w_gb) begin
        b_v_o      = 1'b1;
        b_w_o      = req_w_i[w_ib];
        b_addr_o   = w_addr[w_ib];
        b_data_o   = w_data[w_ib];
        b_w_mask_o = req_w_i[w_ib] ? w_mask[w_ib] : '0;
      end
    end
  end

  for (genvar g = 0; g < reqs_p; g++) begin : g_lane
    bsg_mem_2rw_byte_arb_ctrl_resp_lane #(.width_p(width_p)) u_lane (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .i_rd_a      (w_rd_a[g]),
      .i_rd_b      (w_rd_b[g]),
      .i_a_data    (a_data_i),
      .i_b_data    (b_data_i),
      .o_resp_v    (resp_v_o[g]),
      .o_resp_data (w_resp_data[g])
    );
  end
endmodule

// File: tb/tb_bsg_mem_2rw_byte_arb_ctrl.sv
// Directed bench: a 32-entry instance behind a behavioural SRAM, plus an
// odd-depth (7) instance used only to watch its init sweep.

module tb_bsg_mem_2rw_byte_arb_ctrl;
  localparam int W = 32, ELS = 32, R = 4, AW = 5, MW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [R-1:0]          req_v, req_w, yumi, resp_v;
  logic [R-1:0][AW-1:0]  ra;
  logic [R-1:0][W-1:0]   rd, resp_data;
  logic [R-1:0][MW-1:0]  rm;
  logic                  a_v, a_w, b_v, b_w, init_done;
  logic [AW-1:0]         a_addr, b_addr;
  logic [W-1:0]          a_data, b_data, a_rd, b_rd;
  logic [MW-1:0]         a_mask, b_mask;

  bsg_mem_2rw_byte_arb_ctrl #(.width_p(W), .els_p(ELS), .reqs_p(R), .init_on_reset_p(1)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .req_v_i(req_v), .req_w_i(req_w), .req_addr_i(ra), .req_data_i(rd), .req_mask_i(rm),
    .req_yumi_o(yumi), .resp_v_o(resp_v), .resp_data_o(resp_data),
    .a_v_o(a_v), .a_w_o(a_w), .a_addr_o(a_addr), .a_data_o(a_data), .a_w_mask_o(a_mask),
    .a_data_i(a_rd),
    .b_v_o(b_v), .b_w_o(b_w), .b_addr_o(b_addr), .b_data_o(b_data), .b_w_mask_o(b_mask),
    .b_data_i(b_rd),
    .init_done_o(init_done)
  );

  logic [R-1:0]       y1, rv1;
  logic [R*W-1:0]     rdat1;
  logic               a1_v, a1_w, b1_v, b1_w, init_done1;
  logic [2:0]         a1_addr, b1_addr;
  logic [W-1:0]       a1_data, b1_data;
  logic [MW-1:0]      a1_mask, b1_mask;

  bsg_mem_2rw_byte_arb_ctrl #(.width_p(W), .els_p(7), .reqs_p(R), .init_on_reset_p(1)) dut7 (
    .clk_i(clk), .reset_n_i(rst_n),
    .req_v_i('0), .req_w_i('0), .req_addr_i('0), .req_data_i('0), .req_mask_i('0),
    .req_yumi_o(y1), .resp_v_o(rv1), .resp_data_o(rdat1),
    .a_v_o(a1_v), .a_w_o(a1_w), .a_addr_o(a1_addr), .a_data_o(a1_data), .a_w_mask_o(a1_mask),
    .a_data_i('0),
    .b_v_o(b1_v), .b_w_o(b1_w), .b_addr_o(b1_addr), .b_data_o(b1_data), .b_w_mask_o(b1_mask),
    .b_data_i('0),
    .init_done_o(init_done1)
  );

  // Behavioural 2rw byte-masked SRAM, one-cycle read latency.
  logic [W-1:0] mem [ELS];
  always @(posedge clk) begin
    if (a_v) begin
      if (a_w) begin
        for (int j = 0; j < MW; j++) if (a_mask[j]) mem[a_addr][8*j +: 8] <= a_data[8*j +: 8];
      end else a_rd <= mem[a_addr];
    end
    if (b_v) begin
      if (b_w) begin
        for (int j = 0; j < MW; j++) if (b_mask[j]) mem[b_addr][8*j +: 8] <= b_data[8*j +: 8];
      end else b_rd <= mem[b_addr];
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    req_v = '1; req_w = '0; rd = '0; rm = '0;
    for (int i = 0; i < R; i++) ra[i] = AW'(8 + i);
    #2;
    chk("rst_init_done", init_done, 0);
    chk("rst_yumi", yumi, 0);
    chk("rst_resp_v", resp_v, 0);
    chk("rst_init_done7", init_done1, 0);

    step(); rst_n = 1'b1; #1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin step(); #1; end
      chk("init_a_addr", a_addr, 2*k);
      chk("init_b_addr", b_addr, 2*k + 1);
      chk("init_ctl", {a_v, a_w, b_v, b_w, a_mask, b_mask}, {4'hF, 8'hFF});
      chk("init_data", {a_data, b_data}, 0);
      chk("init_yumi", yumi, 0);
      chk("init_done", init_done, 0);
      if (k < 4) begin
        chk("odd_a", {a1_v, a1_w, a1_addr}, {2'b11, 3'(2*k)});
        chk("odd_b", {b1_v, b1_addr}, (k < 3) ? {1'b1, 3'(2*k + 1)} : 4'b0000);
        chk("odd_done", init_done1, 0);
      end else if (k == 4) begin
        chk("odd_done_run", init_done1, 1);
        chk("odd_idle", {a1_v, b1_v}, 0);
      end
    end

    // first grants, all four reading distinct addresses
    step(); #1;
    chk("run_done", init_done, 1);
    chk("g01_yumi", yumi, 4'b0011);
    chk("g01_addr", {a_addr, b_addr}, {5'd8, 5'd9});
    chk("g01_ctl", {a_v, a_w, b_v, b_w, a_mask, b_mask}, {4'b1010, 8'h00});
    step(); #1;
    chk("g23_yumi", yumi, 4'b1100);
    chk("g23_addr", {a_addr, b_addr}, {5'd10, 5'd11});
    chk("g01_resp_v", resp_v, 4'b0011);
    chk("g01_resp_d", {resp_data[0], resp_data[1]}, 0);
    step(); #1;
    chk("g01b_yumi", yumi, 4'b0011);
    chk("g23_resp_v", resp_v, 4'b1100);
    step(); req_v = '0; #1;
    chk("g01b_resp_v", resp_v, 4'b0011);
    chk("idle_yumi", yumi, 0);

    // pointer = 2: lone full-word write from req0
    step(); req_v = 4'b0001; req_w = 4'b0001; ra[0] = 5'd16; rd[0] = 32'h11223344; rm[0] = 4'hF; #1;
    chk("wr0_yumi", yumi, 4'b0001);
    chk("wr0_port", {a_v, a_w, a_addr, a_mask, b_v}, {2'b11, 5'd16, 4'hF, 1'b0});
    chk("wr0_data", a_data, 32'h11223344);
    chk("wr_no_resp", resp_v, 0);

    // pointer = 1: req1 partial write vs req2 read of same address
    step(); req_v = 4'b0110; req_w = 4'b0010;
    ra[1] = 5'd16; rd[1] = 32'h0000AABB; rm[1] = 4'h3; ra[2] = 5'd16; #1;
    chk("cf_yumi", yumi, 4'b0010);
    chk("cf_b_idle", {b_v, b_w, b_addr, b_mask}, 0);
    chk("cf_a", {a_v, a_w, a_addr, a_mask}, {2'b11, 5'd16, 4'h3});
    chk("cf_a_data", a_data, 32'h0000AABB);
    step(); req_v = 4'b0100; #1;
    chk("cf2_yumi", yumi, 4'b0100);
    chk("cf2_port", {a_v, a_w, a_addr, a_mask}, {2'b10, 5'd16, 4'h0});
    step(); req_v = '0; #1;
    chk("cf2_resp_v", resp_v, 4'b0100);
    chk("cf2_resp_d", resp_data[2], 32'h1122AABB);

    // zero-mask write is still issued
    step(); req_v = 4'b1000; req_w = 4'b1000; ra[3] = 5'd16; rd[3] = 32'hFFFFFFFF; rm[3] = 4'h0; #1;
    chk("m0_yumi", yumi, 4'b1000);
    chk("m0_port", {a_v, a_w, a_addr, a_mask}, {2'b11, 5'd16, 4'h0});

    // two reads of the same address, pointer = 0
    step(); req_v = 4'b1001; req_w = '0; ra[0] = 5'd16; #1;
    chk("rr_yumi", yumi, 4'b1001);
    chk("rr_port", {a_v, a_w, a_addr, b_v, b_w, b_addr}, {2'b10, 5'd16, 2'b10, 5'd16});
    step(); req_v = '0; #1;
    chk("rr_resp_v", resp_v, 4'b1001);
    chk("rr_resp_a", resp_data[0], 32'h1122AABB);
    chk("rr_resp_b", resp_data[3], 32'h1122AABB);

    // back-to-back grants to a lone requester
    step(); req_v = 4'b0010; #1;
    chk("bb1_yumi", yumi, 4'b0010);
    step(); #1;
    chk("bb2_yumi", yumi, 4'b0010);
    chk("bb2_resp_v", resp_v, 4'b0010);
    step(); req_v = '0; #1;
    chk("bb3_resp_v", resp_v, 4'b0010);
    chk("bb3_resp_d", resp_data[1], 32'h1122AABB);
    step(); #1;
    chk("bb_pulse_end", resp_v, 0);

    // reset while a read response is pending
    step(); req_v = 4'b0100; #1;
    chk("pend_yumi", yumi, 4'b0100);
    @(posedge clk); #1; req_v = '0;
    chk("pend_resp_v", resp_v, 4'b0100);
    rst_n = 1'b0; #1;
    chk("rst_drop_resp", resp_v, 0);
    chk("rst_back_init", {init_done, a_v, a_w, a_addr}, {3'b011, 5'd0});

    // reset mid-sweep at counter 3, then restart from address 0
    step(); rst_n = 1'b1; #1;
    chk("re_k0", {a_addr, b_addr}, {5'd0, 5'd1});
    step(); step(); step(); #1;
    chk("re_k3", {a_addr, b_addr}, {5'd6, 5'd7});
    rst_n = 1'b0; #1;
    chk("re_rst_addr", {a_addr, b_addr}, {5'd0, 5'd1});
    step(); rst_n = 1'b1; #1;
    chk("re2_k0", {a_v, a_addr, b_addr}, {1'b1, 5'd0, 5'd1});
    step(); #1;
    chk("re2_k1", {a_addr, b_addr}, {5'd2, 5'd3});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bsg_mem_2rw_byte_arb_ctrl.md
Name: bsg_mem_2rw_byte_arb_ctrl

Overview:
- Shares one dual-port, byte-masked synchronous SRAM (ports A and B, 1-cycle read latency) among reqs_p requesters.
- Grants up to two requests per cycle using round-robin fairness.
- Detects same-address conflicts between the two grants.
- Zero-initialises the whole memory after reset.
- Sits between cache/DMA clients and the 2rw byte-write memory macro.

Parameters:
width_p, 64, data width in bits; must be a multiple of 8
els_p, 512, memory depth; odd values allowed
reqs_p, 4, number of requesters; at least 2
init_on_reset_p, 1, 1 = zero-fill memory after reset before serving requests
addr_width_lp, clog2(els_p), address width (derived)
mask_width_lp, width_p/8, byte-mask width (derived)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
req_v_i  in  reqs_p  request valid per requester
req_w_i  in  reqs_p  1 = write, 0 = read
req_addr_i  in  reqs_p*addr_width_lp  request address, requester i at slice i
req_data_i  in  reqs_p*width_p  write data
req_mask_i  in  reqs_p*mask_width_lp  write byte mask
req_yumi_o  out  reqs_p  request accepted this cycle
resp_v_o  out  reqs_p  read data valid
resp_data_o  out  reqs_p*width_p  read data, slice i belongs to requester i
a_v_o, a_w_o  out  1 each  memory port A valid/write
a_addr_o  out  addr_width_lp  port A address
a_data_o  out  width_p  port A write data
a_w_mask_o  out  mask_width_lp  port A byte mask
a_data_i  in  width_p  port A read data
b_v_o, b_w_o, b_addr_o, b_data_o, b_w_mask_o, b_data_i  same as A  memory port B
init_done_o  out  1  memory ready; requests may be granted

Behaviour:
- Reset (async, reset_n_i=0):
  - State goes to INIT if init_on_reset_p=1, otherwise RUN.
  - Init counter = 0, round-robin pointer = 0, resp_v_o = 0.
  - init_done_o = !init_on_reset_p.
  - Memory-port outputs are combinational from state; they are 0 whenever no access is issued.
- INIT state:
  - Each cycle, port A writes addr 2k and port B writes addr 2k+1; data = 0, mask = all ones, k = counter.
  - If 2k+1 >= els_p, port B is idle.
  - Counter increments by 1 per cycle. The sweep lasts ceil(els_p/2) cycles.
  - After the final sweep cycle: state = RUN and init_done_o = 1 on the next edge.
  - req_yumi_o = 0 throughout INIT.
- RUN state, per cycle (combinational arbitration):
  - Scan requesters starting at the pointer, wrapping modulo reqs_p.
  - First valid requester goes to port A; second valid requester goes to port B.
  - Conflict: if both grants have equal addresses and at least one is a write, the B grant is dropped. That requester stays un-yumied.
  - Two reads to the same address are both granted.
  - req_yumi_o[i] = 1 for each granted requester, same cycle.
  - Requester must hold v/w/addr/data/mask stable until yumi.
- Port drive:
  - v = 1; w = req_w; data and mask passed through.
  - Reads drive mask = 0.
  - A write with mask = 0 is still granted and issued.
- Pointer:
  - Registered; next value = (index of last granted requester + 1) mod reqs_p.
  - Unchanged when nothing is granted.
- Read response:
  - A read granted in cycle t gives resp_v_o[i] = 1 in cycle t+1 only.
  - resp_data_o slice i = a_data_i or b_data_i, according to the port used in cycle t.
  - Slices without a valid response are don't-care.
  - Writes produce no response.
- A requester may re-request in the cycle after its yumi. Back-to-back grants to the same requester are legal when it is the only one valid.
- Read-after-write to the same address in later cycles returns the new data; ordering is guaranteed by the memory.
- Reset asserted mid-INIT or mid-RUN:
  - Pending responses are discarded (resp_v_o = 0).
  - Init restarts from address 0.

Test Plan:
- els_p=8, init_on_reset_p=1, release reset, all req_v_i=1 -> 4 cycles of writes to (0,1), (2,3), (4,5), (6,7), zero data, mask 0xFF; yumi = 0 throughout; init_done_o = 1 in cycle 5; first grants to requesters 0 (A) and 1 (B) in cycle 5.
- els_p=7 -> 4th init cycle writes addr 6 on A only, b_v_o = 0.
- reqs_p=4, all valid with distinct-address reads, held valid -> grant pairs (0,1), (2,3), (0,1) on successive cycles; resp_v_o for each pair one cycle after its grant, carrying the port data.
- Req1 writes 0x10 with data 0xAABB and mask 0x03 while req2 reads 0x10, pointer=1 -> only req1 granted; req2 granted next cycle and reads back 0xAABB in the low bytes.
- Req0 and req3 both read addr 5 -> both granted in the same cycle; both resp_v_o pulse next cycle.
- Assert reset_n_i mid-INIT at counter 3 and during a pending read -> resp_v_o drops immediately; init resumes from address 0 after release.
